// File: rtl/elevator_controller.sv
// Single-car SCAN/collective elevator scheduler: moves the car floor by floor,
// opens the door at served floors and returns one-cycle clear pulses to the button latches.
module elevator_controller #(
   parameter int FLOORS      = 8,
   parameter int FLOOR_W     = 3,
   parameter int MOVE_CYCLES = 16,
   parameter int DOOR_CYCLES = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [FLOORS-1:0]  active_in_levels,
   input  logic [FLOORS-1:0]  active_out_up_levels,
   input  logic [FLOORS-1:0]  active_out_down_levels,
   output logic [FLOORS-1:0]  inactivate_in_levels,
   output logic [FLOORS-1:0]  inactivate_out_up_levels,
   output logic [FLOORS-1:0]  inactivate_out_down_levels,
   output logic [FLOOR_W-1:0] current_floor,
   output logic               dir_up,
   output logic               moving,
   output logic               door_open
);

   localparam int MAX_CYCLES = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
   localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [TIMER_W-1:0] MOVE_LAST = TIMER_W'(MOVE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] DOOR_LAST = TIMER_W'(DOOR_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
   localparam logic [FLOOR_W-1:0] FLOOR_ONE = FLOOR_W'(1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_MOVING = 2'd1;
   localparam logic [1:0] ST_ARRIVE = 2'd2;
   localparam logic [1:0] ST_DOOR   = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [FLOOR_W-1:0] floor_q, floor_d;
   logic               dir_up_q, dir_up_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [FLOORS-1:0]  inact_in_q, inact_in_d;
   logic [FLOORS-1:0]  inact_up_q, inact_up_d;
   logic [FLOORS-1:0]  inact_dn_q, inact_dn_d;
   logic               moving_q, moving_d;
   logic               door_open_q, door_open_d;

   logic [FLOORS-1:0]  req;
   logic [FLOORS-1:0]  floor_sel;
   logic               above, below, fwd;
   logic               in_here, up_here, dn_here, req_here;
   logic               same_here, opp_here, stop_here;

   // Request view relative to the car's current floor.
   always_comb begin
      req       = active_in_levels | active_out_up_levels | active_out_down_levels;
      floor_sel = {{(FLOORS-1){1'b0}}, 1'b1} << floor_q;
      above     = 1'b0;
      below     = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
         if (i > int'(floor_q)) above = above | req[i];
         if (i < int'(floor_q)) below = below | req[i];
      end
      in_here   = active_in_levels[floor_q];
      up_here   = active_out_up_levels[floor_q];
      dn_here   = active_out_down_levels[floor_q];
      req_here  = req[floor_q];
      fwd       = dir_up_q ? above : below;
      same_here = dir_up_q ? up_here : dn_here;
      opp_here  = dir_up_q ? dn_here : up_here;
      stop_here = in_here | same_here | (!fwd & req_here);
   end

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path can infer a latch.
      state_d    = state_q;
      floor_d    = floor_q;
      dir_up_d   = dir_up_q;
      timer_d    = timer_q;
      inact_in_d = '0;
      inact_up_d = '0;
      inact_dn_d = '0;

      case (state_q)
         ST_IDLE: begin
            if (req_here) begin
               state_d    = ST_DOOR;
               timer_d    = DOOR_LAST;
               inact_in_d = in_here ? floor_sel : '0;
               inact_up_d = up_here ? floor_sel : '0;
               inact_dn_d = dn_here ? floor_sel : '0;
            end else if (above || below) begin
               dir_up_d = above;
               state_d  = ST_MOVING;
               timer_d  = MOVE_LAST;
            end
         end
         ST_MOVING: begin
            if (timer_q == '0) begin
               state_d = ST_ARRIVE;
               floor_d = dir_up_q ? floor_q + FLOOR_ONE : floor_q - FLOOR_ONE;
            end else begin
               timer_d = timer_q - TIMER_ONE;
            end
         end
         ST_ARRIVE: begin
            if (stop_here) begin
               state_d    = ST_DOOR;
               timer_d    = DOOR_LAST;
               inact_in_d = in_here ? floor_sel : '0;
               // With nothing further ahead both hall calls here are collected.
               inact_up_d = (up_here && (dir_up_q || !fwd)) ? floor_sel : '0;
               inact_dn_d = (dn_here && (!dir_up_q || !fwd)) ? floor_sel : '0;
               if (!fwd && opp_here) dir_up_d = !dir_up_q;
            end else if (fwd) begin
               state_d = ST_MOVING;
               timer_d = MOVE_LAST;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DOOR: begin
            if (timer_q == '0) state_d = ST_IDLE;
            else               timer_d = timer_q - TIMER_ONE;
         end
         default: state_d = ST_IDLE;
      endcase

      moving_d    = (state_d == ST_MOVING);
      door_open_d = (state_d == ST_DOOR);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         floor_q     <= '0;
         dir_up_q    <= 1'b1;
         timer_q     <= '0;
         inact_in_q  <= '0;
         inact_up_q  <= '0;
         inact_dn_q  <= '0;
         moving_q    <= 1'b0;
         door_open_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         floor_q     <= floor_d;
         dir_up_q    <= dir_up_d;
         timer_q     <= timer_d;
         inact_in_q  <= inact_in_d;
         inact_up_q  <= inact_up_d;
         inact_dn_q  <= inact_dn_d;
         moving_q    <= moving_d;
         door_open_q <= door_open_d;
      end
   end

   assign inactivate_in_levels       = inact_in_q;
   assign inactivate_out_up_levels   = inact_up_q;
   assign inactivate_out_down_levels = inact_dn_q;
   assign current_floor              = floor_q;
   assign dir_up                     = dir_up_q;
   assign moving                     = moving_q;
   assign door_open                  = door_open_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Self-checking bench for elevator_controller: a floor-level scheduling model builds an
// expected per-cycle timeline that is compared against the DUT outputs every cycle.
module tb_elevator_controller;

   localparam int F  = 8;
   localparam int FW = 3;
   localparam int M  = 16;
   localparam int D  = 32;
   localparam int N  = 4096;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [F-1:0]  req_in = '0, req_up = '0, req_dn = '0;
   logic [F-1:0]  inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels;
   logic [FW-1:0] current_floor;
   logic          dir_up, moving, door_open;

   int n_cmp = 0;
   int n_bad = 0;

   // Car position the model assumes at the start of the next scenario.
   int mdl_floor = 0;
   bit mdl_dir   = 1'b1;

   // Scheduled request injections: relative cycle, kind (0 in, 1 up, 2 down), floor.
   int inj_t [16];
   int inj_k [16];
   int inj_f [16];
   int n_inj = 0;

   // Expected timeline, indexed by cycle relative to scenario start.
   logic [F-1:0] tl_pin [N];
   logic [F-1:0] tl_pup [N];
   logic [F-1:0] tl_pdn [N];
   int           tl_floor [N];
   bit           tl_dir [N];
   bit           tl_mov [N];
   bit           tl_door [N];

   elevator_controller #(.FLOORS(F), .FLOOR_W(FW), .MOVE_CYCLES(M), .DOOR_CYCLES(D)) dut (
      .clk                        (clk),
      .reset                      (reset),
      .active_in_levels           (req_in),
      .active_out_up_levels       (req_up),
      .active_out_down_levels     (req_dn),
      .inactivate_in_levels       (inactivate_in_levels),
      .inactivate_out_up_levels   (inactivate_out_up_levels),
      .inactivate_out_down_levels (inactivate_out_down_levels),
      .current_floor              (current_floor),
      .dir_up                     (dir_up),
      .moving                     (moving),
      .door_open                  (door_open)
   );

   always #5 clk = ~clk;

   // One clock; the button latches drop whatever the controller pulsed.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      req_in = req_in & ~inactivate_in_levels;
      req_up = req_up & ~inactivate_out_up_levels;
      req_dn = req_dn & ~inactivate_out_down_levels;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      mdl_floor = 0;
      mdl_dir   = 1'b1;
   endtask

   task automatic add_inj(input int t, input int k, input int f);
      inj_t[n_inj] = t;
      inj_k[n_inj] = k;
      inj_f[n_inj] = f;
      n_inj++;
   endtask

   function automatic bit any_above(input logic [F-1:0] r, input int f);
      bit a = 1'b0;
      for (int i = f + 1; i < F; i++) a = a | r[i];
      return a;
   endfunction

   function automatic bit any_below(input logic [F-1:0] r, input int f);
      bit b = 1'b0;
      for (int i = 0; i < f; i++) b = b | r[i];
      return b;
   endfunction

   function automatic void add_due(input int t, inout int ptr,
                                   inout logic [F-1:0] a, inout logic [F-1:0] u, inout logic [F-1:0] d);
      while (ptr < n_inj && inj_t[ptr] <= t) begin
         case (inj_k[ptr])
            0:       a[inj_f[ptr]] = 1'b1;
            1:       u[inj_f[ptr]] = 1'b1;
            default: d[inj_f[ptr]] = 1'b1;
         endcase
         ptr++;
      end
   endfunction

   function automatic void mark_stop(input int ts, input int f, input bit bi, input bit bu, input bit bd);
      tl_pin[ts][f] = bi;
      tl_pup[ts][f] = bu;
      tl_pdn[ts][f] = bd;
      for (int i = ts; i < ts + D; i++) tl_door[i] = 1'b1;
   endfunction

   function automatic void set_floor_from(input int ts, input int f);
      for (int i = ts; i < N; i++) tl_floor[i] = f;
   endfunction

   function automatic void set_dir_from(input int ts, input bit d);
      for (int i = ts; i < N; i++) tl_dir[i] = d;
   endfunction

   // Floor-level walk of the scheduling rules; times: travel M+1 per floor, stop opens 1 cycle after decision.
   task automatic build_model(output int t_end, output int f_end, output bit d_end);
      logic [F-1:0] m_in, m_up, m_dn, all;
      int  t, f, ptr;
      bit  d, fwd, done, travelling, serve_up, serve_dn;
      m_in = req_in; m_up = req_up; m_dn = req_dn;
      f = mdl_floor; d = mdl_dir; t = 0; ptr = 0; done = 1'b0;
      for (int i = 0; i < N; i++) begin
         tl_pin[i] = '0; tl_pup[i] = '0; tl_pdn[i] = '0;
         tl_floor[i] = f; tl_dir[i] = d; tl_mov[i] = 1'b0; tl_door[i] = 1'b0;
      end
      while (!done) begin
         add_due(t, ptr, m_in, m_up, m_dn);
         all = m_in | m_up | m_dn;
         if (all[f]) begin
            mark_stop(t + 1, f, m_in[f], m_up[f], m_dn[f]);
            m_in[f] = 1'b0; m_up[f] = 1'b0; m_dn[f] = 1'b0;
            t = t + 1 + D;
         end else if (!any_above(all, f) && !any_below(all, f)) begin
            if (ptr < n_inj) t = inj_t[ptr];
            else             done = 1'b1;
         end else begin
            d = any_above(all, f);
            set_dir_from(t + 1, d);
            travelling = 1'b1;
            while (travelling) begin
               for (int i = t + 1; i <= t + M; i++) tl_mov[i] = 1'b1;
               f = d ? f + 1 : f - 1;
               t = t + M + 1;
               set_floor_from(t, f);
               add_due(t, ptr, m_in, m_up, m_dn);
               all = m_in | m_up | m_dn;
               fwd = d ? any_above(all, f) : any_below(all, f);
               serve_up = m_up[f] && (d || !fwd);
               serve_dn = m_dn[f] && (!d || !fwd);
               if (m_in[f] || (d ? m_up[f] : m_dn[f]) || (!fwd && all[f])) begin
                  mark_stop(t + 1, f, m_in[f], serve_up, serve_dn);
                  if (!fwd && (d ? m_dn[f] : m_up[f])) begin
                     d = !d;
                     set_dir_from(t + 1, d);
                  end
                  m_in[f] = 1'b0;
                  if (serve_up) m_up[f] = 1'b0;
                  if (serve_dn) m_dn[f] = 1'b0;
                  t = t + 1 + D;
                  travelling = 1'b0;
               end else if (!fwd) begin
                  t = t + 1;
                  travelling = 1'b0;
               end
               if (t > N - D - 8) begin
                  $display("FAIL model_horizon t=%0d exceeds limit %0d", t, N - D - 8);
                  $fatal(1, "scenario too long");
               end
            end
         end
      end
      t_end = t; f_end = f; d_end = d;
   endtask

   task automatic run_scenario(input string name);
      int t_end, f_end, bad_here;
      bit d_end, aborted;
      logic [3*F+FW+2:0] exp_v, obs_v;
      build_model(t_end, f_end, d_end);
      bad_here = 0;
      aborted  = 1'b0;
      for (int rel = 0; rel <= t_end + 2 && !aborted; rel++) begin
         if (rel > 0) tick();
         exp_v = {tl_pin[rel], tl_pup[rel], tl_pdn[rel], FW'(tl_floor[rel]), tl_dir[rel], tl_mov[rel], tl_door[rel]};
         obs_v = {inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels,
                  current_floor, dir_up, moving, door_open};
         n_cmp++;
         if (obs_v !== exp_v) begin
            n_bad++;
            bad_here++;
            $display("FAIL %s rel=%0d got in=%b up=%b dn=%b floor=%0d dir=%b mov=%b door=%b expected in=%b up=%b dn=%b floor=%0d dir=%b mov=%b door=%b",
                     name, rel, inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels,
                     current_floor, dir_up, moving, door_open,
                     tl_pin[rel], tl_pup[rel], tl_pdn[rel], tl_floor[rel], tl_dir[rel], tl_mov[rel], tl_door[rel]);
            if (bad_here >= 6) aborted = 1'b1;
         end
         for (int i = 0; i < n_inj; i++) begin
            if (inj_t[i] == rel) begin
               case (inj_k[i])
                  0:       req_in[inj_f[i]] = 1'b1;
                  1:       req_up[inj_f[i]] = 1'b1;
                  default: req_dn[inj_f[i]] = 1'b1;
               endcase
            end
         end
      end
      n_inj = 0;
      if (aborted) begin
         req_in = '0; req_up = '0; req_dn = '0;
         apply_reset();
      end else begin
         mdl_floor = f_end;
         mdl_dir   = d_end;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (current_floor !== 3'd0) begin n_bad++; $display("FAIL reset_floor got %0d expected 0", current_floor); end
      n_cmp++; if (dir_up !== 1'b1) begin n_bad++; $display("FAIL reset_dir got %b expected 1", dir_up); end
      n_cmp++; if (moving !== 1'b0) begin n_bad++; $display("FAIL reset_moving got %b expected 0", moving); end
      n_cmp++; if (door_open !== 1'b0) begin n_bad++; $display("FAIL reset_door got %b expected 0", door_open); end
      n_cmp++;
      if ({inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels} !== '0) begin
         n_bad++;
         $display("FAIL reset_pulses got %b/%b/%b expected all 0",
                  inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels);
      end
      reset = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (moving !== 1'b0 || door_open !== 1'b0 || current_floor !== 3'd0) begin
         n_bad++;
         $display("FAIL idle_no_request got mov=%b door=%b floor=%0d expected 0/0/0", moving, door_open, current_floor);
      end
   endtask

   // Reference latency: car call three floors up from rest at floor 0.
   task automatic test_latency();
      apply_reset();
      req_in[3] = 1'b1;
      for (int rel = 1; rel <= 85; rel++) begin
         tick();
         if (rel == 1) begin
            n_cmp++; if (moving !== 1'b1 || current_floor !== 3'd0) begin n_bad++; $display("FAIL lat_start got mov=%b floor=%0d expected 1/0", moving, current_floor); end
         end
         if (rel == 16) begin
            n_cmp++; if (moving !== 1'b1 || current_floor !== 3'd0) begin n_bad++; $display("FAIL lat_move_end got mov=%b floor=%0d expected 1/0", moving, current_floor); end
         end
         if (rel == 17) begin
            n_cmp++; if (moving !== 1'b0 || current_floor !== 3'd1) begin n_bad++; $display("FAIL lat_arrive1 got mov=%b floor=%0d expected 0/1", moving, current_floor); end
         end
         if (rel == 51) begin
            n_cmp++; if (current_floor !== 3'd3 || moving !== 1'b0 || door_open !== 1'b0) begin n_bad++; $display("FAIL lat_arrive3 got floor=%0d mov=%b door=%b expected 3/0/0", current_floor, moving, door_open); end
         end
         if (rel == 52) begin
            n_cmp++;
            if (door_open !== 1'b1 || inactivate_in_levels !== 8'h08 || inactivate_out_up_levels !== 8'h00 || inactivate_out_down_levels !== 8'h00) begin
               n_bad++;
               $display("FAIL lat_door_pulse got door=%b in=%b up=%b dn=%b expected 1/00001000/0/0", door_open,
                        inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels);
            end
         end
         if (rel == 53) begin
            n_cmp++; if (inactivate_in_levels !== 8'h00 || door_open !== 1'b1) begin n_bad++; $display("FAIL lat_pulse_once got in=%b door=%b expected 0/1", inactivate_in_levels, door_open); end
         end
         if (rel == 83) begin
            n_cmp++; if (door_open !== 1'b1) begin n_bad++; $display("FAIL lat_door_last got %b expected 1", door_open); end
         end
         if (rel == 84) begin
            n_cmp++; if (door_open !== 1'b0 || moving !== 1'b0 || current_floor !== 3'd3) begin n_bad++; $display("FAIL lat_idle got door=%b mov=%b floor=%0d expected 0/0/3", door_open, moving, current_floor); end
         end
      end
      mdl_floor = 3;
      mdl_dir   = 1'b1;
   endtask

   task automatic test_pass_through();
      apply_reset();
      add_inj(0, 0, 5);
      add_inj(5, 2, 2);
      run_scenario("pass_through");
   endtask

   task automatic test_same_dir_stop();
      apply_reset();
      add_inj(0, 0, 4);
      add_inj(5, 1, 2);
      run_scenario("same_dir_stop");
   endtask

   task automatic test_top_floor();
      add_inj(0, 0, 7);
      add_inj(100, 0, 7);
      add_inj(100, 1, 7);
      add_inj(100, 2, 7);
      run_scenario("top_floor");
   endtask

   task automatic test_priority();
      add_inj(0, 0, 3);
      run_scenario("goto_3");
      add_inj(0, 1, 6);
      add_inj(0, 2, 1);
      run_scenario("above_first");
   endtask

   task automatic test_door_reopen();
      add_inj(0, 0, 4);
      add_inj(60, 1, 4);
      run_scenario("door_reopen");
   endtask

   task automatic check_after_reset(input string name);
      n_cmp++;
      if (current_floor !== 3'd0 || dir_up !== 1'b1 || moving !== 1'b0 || door_open !== 1'b0 ||
          {inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels} !== '0) begin
         n_bad++;
         $display("FAIL %s got floor=%0d dir=%b mov=%b door=%b pulses=%b/%b/%b expected 0/1/0/0/0", name,
                  current_floor, dir_up, moving, door_open,
                  inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels);
      end
   endtask

   task automatic test_reset_mid_move();
      apply_reset();
      req_in[6] = 1'b1;
      repeat (25) tick();
      n_cmp++; if (moving !== 1'b1 || current_floor !== 3'd1) begin n_bad++; $display("FAIL rst_move_pre got mov=%b floor=%0d expected 1/1", moving, current_floor); end
      reset = 1'b1;
      tick();
      check_after_reset("rst_move_post");
      reset = 1'b0;
      mdl_floor = 0; mdl_dir = 1'b1;
      run_scenario("rst_move_resume");
   endtask

   task automatic test_reset_mid_door();
      apply_reset();
      req_in[2] = 1'b1;
      for (int rel = 1; rel <= 40; rel++) begin
         tick();
         if (rel == 38) req_dn[5] = 1'b1;
      end
      n_cmp++; if (door_open !== 1'b1 || current_floor !== 3'd2) begin n_bad++; $display("FAIL rst_door_pre got door=%b floor=%0d expected 1/2", door_open, current_floor); end
      reset = 1'b1;
      tick();
      check_after_reset("rst_door_post");
      reset = 1'b0;
      mdl_floor = 0; mdl_dir = 1'b1;
      run_scenario("rst_door_resume");
   endtask

   task automatic test_random();
      int t;
      for (int it = 0; it < 12; it++) begin
         t = 0;
         for (int i = 0; i < int'($urandom_range(1, 5)); i++) begin
            t = t + int'($urandom_range(0, 120));
            add_inj(t, int'($urandom_range(0, 2)), int'($urandom_range(0, F - 1)));
         end
         run_scenario($sformatf("random_%0d", it));
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_latency();
      test_pass_through();
      test_same_dir_stop();
      test_top_floor();
      test_priority();
      test_door_reopen();
      test_reset_mid_move();
      test_reset_mid_door();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
